// File: rtl/rgmii_tx_formatter.sv
// RGMII transmit formatter: MAC byte stream to ODDR rise/fall words {tx_ctl, txd[3:0]}.
// Define RGMII_TX_PREAMBLE_EN to generate the 7x0x55 + 0xD5 preamble/SFD in hardware.
module rgmii_tx_formatter #(
    parameter int DATA_WIDTH = 5,
    parameter int IFG_BYTES  = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            s_tx_data,
    input  logic                  s_tx_valid,
    input  logic                  s_tx_last,
    output logic                  s_tx_ready,
    input  logic [1:0]            link_speed,
    output logic [DATA_WIDTH-1:0] o_d1,
    output logic [DATA_WIDTH-1:0] o_d2,
    output logic                  o_busy
);

    localparam int               CNT_W         = $clog2(2 * IFG_BYTES + 1);
    localparam logic [CNT_W-1:0] IFG_LOAD_1G   = CNT_W'(IFG_BYTES - 1);
    localparam logic [CNT_W-1:0] IFG_LOAD_SLOW = CNT_W'(2 * IFG_BYTES - 1);

`ifdef RGMII_TX_PREAMBLE_EN
    localparam logic IDLE_READY = 1'b0;
`else
    localparam logic IDLE_READY = 1'b1;
`endif

    typedef logic [DATA_WIDTH-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        ERR,
        DRAIN,
`ifdef RGMII_TX_PREAMBLE_EN
        PREAMBLE,
`endif
        IFG
    } state_t;

    state_t           state;
    logic             speed_1g;
    logic [3:0]       hi_nib;
    logic             nib_phase;
    logic             last_pending;
    logic [CNT_W-1:0] ifg_cnt;
    logic             link_1g;
    logic             frame_1g;
    logic             data_take;

    function automatic word_t mk_word(input logic ctl, input logic [3:0] nib);
        word_t w;
        w                 = '0;
        w[DATA_WIDTH-1]   = ctl;
        w[3:0]            = nib;
        return w;
    endfunction

    // Speed is latched at frame start; only IDLE looks at the live link_speed.
    assign link_1g  = (link_speed == 2'b10) || (link_speed == 2'b11);
    assign frame_1g = (state == IDLE) ? link_1g : speed_1g;

`ifdef RGMII_TX_PREAMBLE_EN
    logic [3:0] pre_idx;
    logic       pre_final;

    assign pre_final = speed_1g ? (pre_idx == 4'd7) : (pre_idx == 4'd15);
    assign data_take = s_tx_valid && s_tx_ready && (state == DATA);
`else
    assign data_take = s_tx_valid && s_tx_ready && (state == IDLE || state == DATA);
`endif

    // NOTE: every register here uses non-blocking assignment so all outputs update together on the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            s_tx_ready   <= 1'b0;
            o_d1         <= '0;
            o_d2         <= '0;
            o_busy       <= 1'b0;
            speed_1g     <= 1'b0;
            hi_nib       <= 4'h0;
            nib_phase    <= 1'b0;
            last_pending <= 1'b0;
            ifg_cnt      <= '0;
`ifdef RGMII_TX_PREAMBLE_EN
            pre_idx      <= 4'd0;
`endif
        end else if (data_take) begin
            o_busy   <= 1'b1;
            speed_1g <= frame_1g;
            o_d1     <= mk_word(1'b1, s_tx_data[3:0]);
            if (frame_1g) begin
                o_d2 <= mk_word(1'b1, s_tx_data[7:4]);
                if (s_tx_last) begin
                    state      <= IFG;
                    ifg_cnt    <= IFG_LOAD_1G;
                    s_tx_ready <= 1'b0;
                end else begin
                    state <= DATA;
                end
            end else begin
                // Low nibble now, high nibble next cycle; ready reopens with the high nibble.
                o_d2         <= mk_word(1'b1, s_tx_data[3:0]);
                hi_nib       <= s_tx_data[7:4];
                nib_phase    <= 1'b1;
                last_pending <= s_tx_last;
                s_tx_ready   <= 1'b0;
                state        <= DATA;
            end
        end else begin
            case (state)
                IDLE: begin
                    o_d1       <= '0;
                    o_d2       <= '0;
                    o_busy     <= 1'b0;
                    s_tx_ready <= IDLE_READY;
`ifdef RGMII_TX_PREAMBLE_EN
                    if (s_tx_valid) begin
                        state    <= PREAMBLE;
                        speed_1g <= link_1g;
                        o_busy   <= 1'b1;
                        o_d1     <= mk_word(1'b1, 4'h5);
                        o_d2     <= mk_word(1'b1, 4'h5);
                        pre_idx  <= 4'd1;
                    end
`endif
                end

`ifdef RGMII_TX_PREAMBLE_EN
                PREAMBLE: begin
                    o_d1 <= mk_word(1'b1, (pre_final && !speed_1g) ? 4'hD : 4'h5);
                    o_d2 <= mk_word(1'b1, pre_final ? 4'hD : 4'h5);
                    if (pre_final) begin
                        state      <= DATA;
                        nib_phase  <= 1'b0;
                        s_tx_ready <= 1'b1;
                    end else begin
                        pre_idx <= pre_idx + 4'd1;
                    end
                end
`endif

                DATA: begin
                    if (nib_phase) begin
                        o_d1      <= mk_word(1'b1, hi_nib);
                        o_d2      <= mk_word(1'b1, hi_nib);
                        nib_phase <= 1'b0;
                        if (last_pending) begin
                            state      <= IFG;
                            ifg_cnt    <= IFG_LOAD_SLOW;
                            s_tx_ready <= 1'b0;
                        end else begin
                            s_tx_ready <= 1'b1;
                        end
                    end else begin
                        // A slot was open and the MAC offered nothing: flag TX_ER once.
                        o_d1 <= mk_word(1'b1, 4'h0);
                        o_d2 <= mk_word(1'b0, 4'h0);
                        if (speed_1g) begin
                            state <= DRAIN;
                        end else begin
                            state      <= ERR;
                            s_tx_ready <= 1'b0;
                        end
                    end
                end

                ERR: begin
                    o_d1       <= mk_word(1'b1, 4'h0);
                    o_d2       <= mk_word(1'b0, 4'h0);
                    state      <= DRAIN;
                    s_tx_ready <= 1'b1;
                end

                DRAIN: begin
                    o_d1       <= '0;
                    o_d2       <= '0;
                    s_tx_ready <= 1'b1;
                    if (s_tx_valid && s_tx_ready && s_tx_last) begin
                        state      <= IFG;
                        ifg_cnt    <= speed_1g ? IFG_LOAD_1G : IFG_LOAD_SLOW;
                        s_tx_ready <= 1'b0;
                    end
                end

                IFG: begin
                    o_d1       <= '0;
                    o_d2       <= '0;
                    s_tx_ready <= 1'b0;
                    if (ifg_cnt == '0) begin
                        state      <= IDLE;
                        o_busy     <= 1'b0;
                        s_tx_ready <= IDLE_READY;
                    end else begin
                        ifg_cnt <= ifg_cnt - CNT_W'(1);
                    end
                end

                default: begin
                    state      <= IDLE;
                    o_d1       <= '0;
                    o_d2       <= '0;
                    o_busy     <= 1'b0;
                    s_tx_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgmii_tx_formatter.sv
// Directed bench for rgmii_tx_formatter: 1G/100M/10M framing, underrun, speed latch, reset, preamble.
module tb_rgmii_tx_formatter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] s_tx_data;
    logic       s_tx_valid;
    logic       s_tx_last;
    logic       s_tx_ready;
    logic [1:0] link_speed;
    logic [4:0] o_d1;
    logic [4:0] o_d2;
    logic       o_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rgmii_tx_formatter #(
        .DATA_WIDTH(5),
        .IFG_BYTES (12)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_tx_data (s_tx_data),
        .s_tx_valid(s_tx_valid),
        .s_tx_last (s_tx_last),
        .s_tx_ready(s_tx_ready),
        .link_speed(link_speed),
        .o_d1      (o_d1),
        .o_d2      (o_d2),
        .o_busy    (o_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_expect(input string tag, input logic [4:0] d1e, input logic [4:0] d2e,
                               input logic rdy);
        tick();
        check({tag, "_d1"}, 32'(o_d1), 32'(d1e));
        check({tag, "_d2"}, 32'(o_d2), 32'(d2e));
        check({tag, "_rdy"}, 32'(s_tx_ready), 32'(rdy));
    endtask

    // 1G byte: ready must be open before the edge; the word shows right after it.
    task automatic send_1g(input string tag, input logic [7:0] b, input logic last,
                           input logic [4:0] d1e, input logic [4:0] d2e);
        s_tx_valid = 1'b1;
        s_tx_data  = b;
        s_tx_last  = last;
        check({tag, "_rdy_in"}, 32'(s_tx_ready), 32'(1));
        tick_expect(tag, d1e, d2e, !last);
    endtask

    task automatic idle_gap(input string tag, input int n);
        for (int k = 1; k <= n; k++) begin
            tick_expect(tag, 5'h00, 5'h00, (k == n));
        end
        check({tag, "_busy"}, 32'(o_busy), 32'(0));
    endtask

    initial begin
        reset_n    = 1'b0;
        s_tx_data  = 8'h00;
        s_tx_valid = 1'b0;
        s_tx_last  = 1'b0;
        link_speed = 2'b10;
        repeat (2) @(posedge clk);
        #2;
        check("rst_d1", 32'(o_d1), 32'(0));
        check("rst_d2", 32'(o_d2), 32'(0));
        check("rst_busy", 32'(o_busy), 32'(0));
        check("rst_rdy", 32'(s_tx_ready), 32'(0));
        reset_n = 1'b1;

`ifdef RGMII_TX_PREAMBLE_EN
        tick_expect("p_idle", 5'h00, 5'h00, 1'b0);
        s_tx_valid = 1'b1;
        s_tx_data  = 8'hFF;
        s_tx_last  = 1'b1;
        for (int i = 0; i < 7; i++) tick_expect("p_55", 5'h15, 5'h15, 1'b0);
        tick_expect("p_sfd", 5'h15, 5'h1D, 1'b1);
        tick_expect("p_ff", 5'h1F, 5'h1F, 1'b0);
        s_tx_valid = 1'b0;
        s_tx_last  = 1'b0;
        idle_gap("p_ifg", 12);
`else
        tick_expect("rst_rel", 5'h00, 5'h00, 1'b1);

        // 1G frame with in-band preamble
        for (int i = 0; i < 7; i++) send_1g("t1_55", 8'h55, 1'b0, 5'h15, 5'h15);
        send_1g("t1_d5", 8'hD5, 1'b0, 5'h15, 5'h1D);
        send_1g("t1_a1", 8'hA1, 1'b0, 5'h11, 5'h1A);
        send_1g("t1_b2", 8'hB2, 1'b1, 5'h12, 5'h1B);
        s_tx_valid = 1'b0;
        s_tx_last  = 1'b0;
        check("t1_busy", 32'(o_busy), 32'(1));
        idle_gap("t1_ifg", 12);

        // 100M nibble mode
        link_speed = 2'b01;
        s_tx_valid = 1'b1;
        s_tx_data  = 8'h3C;
        s_tx_last  = 1'b0;
        check("t2_rdy_in", 32'(s_tx_ready), 32'(1));
        tick_expect("t2_c", 5'h1C, 5'h1C, 1'b0);
        s_tx_data = 8'h7E;
        s_tx_last = 1'b1;
        tick_expect("t2_3", 5'h13, 5'h13, 1'b1);
        tick_expect("t2_e", 5'h1E, 5'h1E, 1'b0);
        s_tx_valid = 1'b0;
        s_tx_last  = 1'b0;
        tick_expect("t2_7", 5'h17, 5'h17, 1'b0);
        idle_gap("t2_ifg", 24);

        // 1G underrun after two bytes of a five-byte frame
        link_speed = 2'b10;
        send_1g("t3_b0", 8'h11, 1'b0, 5'h11, 5'h11);
        send_1g("t3_b1", 8'h22, 1'b0, 5'h12, 5'h12);
        s_tx_valid = 1'b0;
        tick_expect("t3_err", 5'h10, 5'h00, 1'b1);
        s_tx_valid = 1'b1;
        s_tx_data  = 8'h33;
        tick_expect("t3_drop0", 5'h00, 5'h00, 1'b1);
        s_tx_data = 8'h44;
        tick_expect("t3_drop1", 5'h00, 5'h00, 1'b1);
        s_tx_data = 8'h55;
        s_tx_last = 1'b1;
        tick_expect("t3_drop2", 5'h00, 5'h00, 1'b0);
        s_tx_valid = 1'b0;
        s_tx_last  = 1'b0;
        idle_gap("t3_ifg", 12);

        // speed change mid-frame is ignored, next frame picks up 10M
        send_1g("t4_b0", 8'h12, 1'b0, 5'h12, 5'h11);
        link_speed = 2'b00;
        send_1g("t4_b1", 8'h34, 1'b1, 5'h14, 5'h13);
        s_tx_valid = 1'b0;
        s_tx_last  = 1'b0;
        idle_gap("t4_ifg1g", 12);
        s_tx_valid = 1'b1;
        s_tx_data  = 8'h9A;
        s_tx_last  = 1'b1;
        check("t4_rdy_in", 32'(s_tx_ready), 32'(1));
        tick_expect("t4_lo", 5'h1A, 5'h1A, 1'b0);
        s_tx_valid = 1'b0;
        s_tx_last  = 1'b0;
        tick_expect("t4_hi", 5'h19, 5'h19, 1'b0);
        idle_gap("t4_ifg10", 24);

        // asynchronous reset in the middle of a frame
        link_speed = 2'b10;
        send_1g("t5_b0", 8'hC3, 1'b0, 5'h13, 5'h1C);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_rst_d1", 32'(o_d1), 32'(0));
        check("t5_rst_d2", 32'(o_d2), 32'(0));
        check("t5_rst_busy", 32'(o_busy), 32'(0));
        check("t5_rst_rdy", 32'(s_tx_ready), 32'(0));
        s_tx_valid = 1'b0;
        #2;
        reset_n = 1'b1;
        tick_expect("t5_rel", 5'h00, 5'h00, 1'b1);
        check("t5_rel_busy", 32'(o_busy), 32'(0));
        send_1g("t5_new", 8'h5A, 1'b1, 5'h1A, 5'h15);
        s_tx_valid = 1'b0;
        s_tx_last  = 1'b0;
        idle_gap("t5_ifg", 12);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
